contador_programa: RTL and testbench



---
 rtl/contador_programa.sv | 37 +++
 tb/tb_contador_programa.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/contador_programa.sv
// contador_programa: 32-bit program counter with SEQ/JUMP/BRANCH/JR/LOAD/HOLD next-address select.
// Define CONTADOR_PROGRAMA_ALIGN_EN to force JR/LOAD targets and RESET_ADDR to word alignment.
module contador_programa #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [2:0]  pc_control,
  input  logic [25:0] jump_address,
  input  logic [15:0] branch_offset,
  input  logic [31:0] reg_address,
  input  logic [31:0] pc_in
);
`ifdef CONTADOR_PROGRAMA_ALIGN_EN
  localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] TARGET_MASK = 32'hFFFF_FFFF;
`endif
  localparam logic [31:0] RESET_VAL = RESET_ADDR & TARGET_MASK;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  always_comb begin
    pc_plus4      = pc + 32'd4;
    branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    next_pc = pc_control == 3'b000 ? pc_plus4 :
              pc_control == 3'b001 ? {pc_plus4[31:28], jump_address, 2'b00} :
              pc_control == 3'b010 ? branch_target :
              pc_control == 3'b011 ? reg_address & TARGET_MASK :
              pc_control == 3'b100 ? pc_in & TARGET_MASK :
                                     pc;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= RESET_VAL;
    else      pc <= next_pc;
endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa: directed and randomized checks of contador_programa against an arithmetic model.
module tb_contador_programa;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  pc_control = 3'b000;
  logic [25:0] jump_address = '0;
  logic [15:0] branch_offset = '0;
  logic [31:0] reg_address = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc;
  logic [31:0] exp_pc = '0;
  int tests = 0;
  int fails = 0;
`ifdef CONTADOR_PROGRAMA_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  contador_programa dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_control(pc_control),
    .jump_address(jump_address), .branch_offset(branch_offset),
    .reg_address(reg_address), .pc_in(pc_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] cur, input logic [2:0] c);
    case (c)
      3'd0: return cur + 32'd4;
      3'd1: return ((cur + 32'd4) & 32'hF000_0000) | ({6'b0, jump_address} * 32'd4);
      3'd2: return 32'(longint'(cur) + 64'sd4 + 64'sd4 * longint'($signed(branch_offset)));
      3'd3: return ALIGN ? reg_address & ~32'd3 : reg_address;
      3'd4: return ALIGN ? pc_in & ~32'd3 : pc_in;
      default: return cur;
    endcase
  endfunction

  task automatic tick(input logic [2:0] c);
    pc_control = c;
    exp_pc = model(exp_pc, c);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a);
    pc_in = a;
    tick(3'd4);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pc_control = 3'b000;
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (pc !== 32'h0) begin fails++; $display("FAIL reset_hold[%0d]: pc=%h expected %h", i, pc, 32'h0); end
    end
    rst = 1'b1;
    load(32'h40);
    tests++;
    if (pc !== 32'h40) begin fails++; $display("FAIL reset_preload: pc=%h expected %h", pc, 32'h40); end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (pc !== 32'h0) begin fails++; $display("FAIL reset_async: pc=%h expected %h", pc, 32'h0); end
    rst = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic test_seq();
    for (int i = 0; i < 5; i++) begin
      tick(3'd0);
      tests++;
      if (pc !== 32'(4 * (i + 1))) begin fails++; $display("FAIL seq[%0d]: pc=%h expected %h", i, pc, 32'(4 * (i + 1))); end
    end
    load(32'hFFFF_FFFC);
    tick(3'd0);
    tests++;
    if (pc !== 32'h0) begin fails++; $display("FAIL seq_wrap: pc=%h expected %h", pc, 32'h0); end
  endtask

  task automatic test_jump();
    load(32'h10);
    jump_address = 26'h40;
    tick(3'd1);
    tests++;
    if (pc !== 32'h100) begin fails++; $display("FAIL jump: pc=%h expected %h", pc, 32'h100); end
    load(32'h0FFF_FFFC);
    jump_address = 26'h0;
    tick(3'd1);
    tests++;
    if (pc !== 32'h1000_0000) begin fails++; $display("FAIL jump_region: pc=%h expected %h", pc, 32'h1000_0000); end
  endtask

  task automatic test_branch();
    load(32'h100);
    branch_offset = 16'h0003;
    tick(3'd2);
    tests++;
    if (pc !== 32'h110) begin fails++; $display("FAIL branch_fwd: pc=%h expected %h", pc, 32'h110); end
    load(32'h100);
    branch_offset = 16'hFFFE;
    tick(3'd2);
    tests++;
    if (pc !== 32'hFC) begin fails++; $display("FAIL branch_back: pc=%h expected %h", pc, 32'hFC); end
    load(32'h0);
    branch_offset = 16'h8000;
    tick(3'd2);
    tests++;
    if (pc !== 32'hFFFE_0004) begin fails++; $display("FAIL branch_wrap: pc=%h expected %h", pc, 32'hFFFE_0004); end
  endtask

  task automatic test_jr_load();
    reg_address = 32'h2000;
    tick(3'd3);
    tests++;
    if (pc !== 32'h2000) begin fails++; $display("FAIL jr: pc=%h expected %h", pc, 32'h2000); end
    load(32'h3003);
    tests++;
    if (pc !== (ALIGN ? 32'h3000 : 32'h3003)) begin fails++; $display("FAIL load_low_bits: pc=%h expected %h", pc, ALIGN ? 32'h3000 : 32'h3003); end
    reg_address = 32'h1003;
    tick(3'd3);
    tests++;
    if (pc !== (ALIGN ? 32'h1000 : 32'h1003)) begin fails++; $display("FAIL jr_low_bits: pc=%h expected %h", pc, ALIGN ? 32'h1000 : 32'h1003); end
  endtask

  task automatic test_hold();
    load(32'h500);
    for (int c = 5; c < 8; c++)
      for (int k = 0; k < 2; k++) begin
        jump_address = 26'($urandom);
        branch_offset = 16'($urandom);
        reg_address = $urandom;
        pc_in = $urandom;
        tick(3'(c));
        tests++;
        if (pc !== 32'h500) begin fails++; $display("FAIL hold_code%0d[%0d]: pc=%h expected %h", c, k, pc, 32'h500); end
      end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      jump_address = 26'($urandom);
      branch_offset = 16'($urandom);
      reg_address = $urandom;
      pc_in = $urandom;
      if ($urandom_range(0, 24) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        exp_pc = 32'h0;
        tests++;
        if (pc !== exp_pc) begin fails++; $display("FAIL random_reset[%0d]: pc=%h expected %h", i, pc, exp_pc); end
        rst = 1'b1;
      end
      tick(3'($urandom_range(0, 7)));
      tests++;
      if (pc !== exp_pc) begin fails++; $display("FAIL random[%0d]: code=%0d pc=%h expected %h", i, pc_control, pc, exp_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_jump();
    test_branch();
    test_jr_load();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
